// File: rtl/fc_argmax_reader.sv
// rtl/fc_argmax_reader.sv - captures ten class scores, scans for the argmax, reports winner and margin
module fc_argmax_reader #(
    parameter int N_CLASS = 10,
    parameter int DW      = 16,
    parameter int IW      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] OR1_1,
    input  logic signed [DW-1:0] OR1_2,
    input  logic signed [DW-1:0] OR1_3,
    input  logic signed [DW-1:0] OR1_4,
    input  logic signed [DW-1:0] OR1_5,
    input  logic signed [DW-1:0] OR1_6,
    input  logic signed [DW-1:0] OR1_7,
    input  logic signed [DW-1:0] OR1_8,
    input  logic signed [DW-1:0] OR1_9,
    input  logic signed [DW-1:0] OR1_10,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IW-1:0]        out_class,
    output logic signed [DW-1:0] out_score,
    output logic [DW:0]          out_margin,
    output logic [7:0]           drop_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IW-1:0]        LAST_IDX  = IW'(N_CLASS - 1);
    localparam logic signed [DW-1:0] MIN_SCORE = {1'b1, {(DW-1){1'b0}}};

    logic signed [DW-1:0] in_scores [N_CLASS];

    assign in_scores[0] = OR1_1;
    assign in_scores[1] = OR1_2;
    assign in_scores[2] = OR1_3;
    assign in_scores[3] = OR1_4;
    assign in_scores[4] = OR1_5;
    assign in_scores[5] = OR1_6;
    assign in_scores[6] = OR1_7;
    assign in_scores[7] = OR1_8;
    assign in_scores[8] = OR1_9;
    assign in_scores[9] = OR1_10;

    logic [1:0]           state_q,      state_d;
    logic [IW-1:0]        idx_q,        idx_d;
    logic signed [DW-1:0] score_q [N_CLASS];
    logic signed [DW-1:0] score_d [N_CLASS];
    logic signed [DW-1:0] best_q,       best_d;
    logic signed [DW-1:0] second_q,     second_d;
    logic [IW-1:0]        bidx_q,       bidx_d;
    logic                 out_valid_q,  out_valid_d;
    logic [IW-1:0]        out_class_q,  out_class_d;
    logic signed [DW-1:0] out_score_q,  out_score_d;
    logic [DW:0]          out_margin_q, out_margin_d;
    logic [7:0]           drop_cnt_q,   drop_cnt_d;
    logic signed [DW-1:0] cur_score;

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = out_valid_q;
    assign out_class  = out_class_q;
    assign out_score  = out_score_q;
    assign out_margin = out_margin_q;
    assign drop_cnt   = drop_cnt_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        score_d      = score_q;
        best_d       = best_q;
        second_d     = second_q;
        bidx_d       = bidx_q;
        out_valid_d  = out_valid_q;
        out_class_d  = out_class_q;
        out_score_d  = out_score_q;
        out_margin_d = out_margin_q;
        drop_cnt_d   = drop_cnt_q;
        cur_score    = score_q[idx_q];

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    score_d  = in_scores;
                    best_d   = in_scores[0];
                    bidx_d   = '0;
                    second_d = MIN_SCORE;
                    idx_d    = IW'(1);
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                // Strict compare keeps the lowest index on ties; the tied value drops to second.
                if (cur_score > best_q) begin
                    second_d = best_q;
                    best_d   = cur_score;
                    bidx_d   = idx_q;
                end else if (cur_score > second_q) begin
                    second_d = cur_score;
                end
                if (idx_q == LAST_IDX) begin
                    out_class_d  = bidx_d;
                    out_score_d  = best_d;
                    out_margin_d = {best_d[DW-1], best_d} - {second_d[DW-1], second_d};
                    out_valid_d  = 1'b1;
                    idx_d        = '0;
                    state_d      = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Vectors offered while busy are lost; count them, saturating.
        if (in_valid && !in_ready && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            for (int i = 0; i < N_CLASS; i++) begin
                score_q[i] <= '0;
            end
            best_q       <= '0;
            second_q     <= '0;
            bidx_q       <= '0;
            out_valid_q  <= 1'b0;
            out_class_q  <= '0;
            out_score_q  <= '0;
            out_margin_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            score_q      <= score_d;
            best_q       <= best_d;
            second_q     <= second_d;
            bidx_q       <= bidx_d;
            out_valid_q  <= out_valid_d;
            out_class_q  <= out_class_d;
            out_score_q  <= out_score_d;
            out_margin_q <= out_margin_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_fc_argmax_reader.sv
// tb/tb_fc_argmax_reader.sv - scoreboard bench for fc_argmax_reader
module tb_fc_argmax_reader;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b1;
    logic signed [15:0] or1 [10];
    logic              in_ready;
    logic              out_valid;
    logic [3:0]        out_class;
    logic signed [15:0] out_score;
    logic [16:0]       out_margin;
    logic [7:0]        drop_cnt;

    typedef struct packed {
        logic [3:0]  c;
        logic [15:0] s;
        logic [16:0] m;
    } res_t;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_drop = 0;

    fc_argmax_reader dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .OR1_1(or1[0]), .OR1_2(or1[1]), .OR1_3(or1[2]), .OR1_4(or1[3]), .OR1_5(or1[4]),
        .OR1_6(or1[5]), .OR1_7(or1[6]), .OR1_8(or1[7]), .OR1_9(or1[8]), .OR1_10(or1[9]),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_score(out_score), .out_margin(out_margin), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every accepted result is popped and checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            res_t e;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: class %0d score %0d with empty scoreboard", out_class, out_score);
            end else begin
                e = exp_q.pop_front();
                chk("out_class",  {28'd0, out_class},  {28'd0, e.c});
                chk("out_score",  {16'd0, out_score},  {16'd0, e.s});
                chk("out_margin", {15'd0, out_margin}, {15'd0, e.m});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int v [10]);
        for (int i = 0; i < 10; i++) or1[i] = 16'(v[i]);
    endtask

    task automatic send(input int v [10], input int c, input int s, input int m, input bit push);
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        load(v);
        if (push) exp_q.push_back({4'(c), 16'(s), 17'(m)});
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_valid_timeout: got 0 after %0d cycles expected 1", cyc);
        end
    endtask

    task automatic run(input int v [10], input int c, input int s, input int m);
        int cyc;
        send(v, c, s, m, 1'b1);
        wait_valid(cyc);
        chk("latency", 32'(cyc), 32'd9);
        tick();
        chk("out_valid_after_handoff", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after_handoff", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int v [10];
        int cyc;
        for (int i = 0; i < 10; i++) or1[i] = '0;

        tick();
        tick();
        chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
        chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
        chk("rst_out_class",  {28'd0, out_class},  32'd0);
        chk("rst_out_score",  {16'd0, out_score},  32'd0);
        chk("rst_out_margin", {15'd0, out_margin}, 32'd0);
        chk("rst_drop_cnt",   {24'd0, drop_cnt},   32'd0);
        rst_n = 1'b1;
        tick();

        v = '{5, -3, 100, 7, 0, 0, 0, 0, 0, 0};
        run(v, 2, 100, 93);
        v = '{0, 0, 0, 50, 0, 50, 0, 0, 0, 50};
        run(v, 3, 50, 0);
        v = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, 32767};
        run(v, 9, 32767, 65535);
        v = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        run(v, 0, -32768, 0);

        // Result held in DONE while busy inputs are offered every cycle.
        out_ready = 1'b0;
        v = '{10, 20, 30, 40, 50, 60, 70, 80, 90, -1};
        send(v, 8, 90, 10, 1'b1);
        wait_valid(cyc);
        for (int i = 0; i < 20; i++) begin
            v = '{1000 + i, 2000, 3000, 4000, 5000, 6000, 7000, 8000, 9000, 10000};
            load(v);
            in_valid = 1'b1;
            tick();
            exp_drop++;
            chk("hold_drop_cnt",   {24'd0, drop_cnt},   32'(exp_drop));
            chk("hold_out_valid",  {31'd0, out_valid},  32'd1);
            chk("hold_out_class",  {28'd0, out_class},  32'd8);
            chk("hold_out_score",  {16'd0, out_score},  32'd90);
            chk("hold_out_margin", {15'd0, out_margin}, 32'd10);
        end
        out_ready = 1'b1;
        tick();
        exp_drop++;
        in_valid = 1'b0;
        chk("handoff_drop_cnt",  {24'd0, drop_cnt},  32'(exp_drop));
        chk("handoff_out_valid", {31'd0, out_valid}, 32'd0);
        chk("handoff_in_ready",  {31'd0, in_ready},  32'd1);
        tick();
        chk("no_capture_in_ready",  {31'd0, in_ready},  32'd1);
        chk("no_capture_out_valid", {31'd0, out_valid}, 32'd0);

        // Scores wiggle during SCAN; only the latched vector counts.
        v = '{-5, -10, -1, -7, -2, -100, -3, -4, -50, -6};
        send(v, 2, -1, 1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 10; j++) or1[j] = 16'($urandom);
            tick();
        end
        wait_valid(cyc);
        tick();
        chk("scan_change_out_valid", {31'd0, out_valid}, 32'd0);

        // Reset sampled while the scan is at index 5.
        v = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        send(v, 9, 10, 1, 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_drop = 0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("midrst_drop_cnt",  {24'd0, drop_cnt},  32'd0);
        v = '{300, -200, 299, 0, 0, 0, 0, 0, 0, 0};
        run(v, 0, 300, 1);

        // Drop counter saturation.
        out_ready = 1'b0;
        v = '{0, 0, 0, 50, 0, 50, 0, 0, 0, 50};
        send(v, 3, 50, 0, 1'b1);
        wait_valid(cyc);
        in_valid = 1'b1;
        repeat (300) tick();
        in_valid = 1'b0;
        chk("sat_drop_cnt",  {24'd0, drop_cnt},  32'd255);
        chk("sat_out_valid", {31'd0, out_valid}, 32'd1);
        chk("sat_out_class", {28'd0, out_class}, 32'd3);
        out_ready = 1'b1;
        tick();
        chk("sat_handoff_out_valid", {31'd0, out_valid}, 32'd0);

        repeat (3) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
